// File: rtl/uart_cmd_pkg.sv
// UART command parser shared definitions:
// opcodes, FSM states and timeout helpers.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR  = 8'h77;
  localparam logic [7:0] OP_RD  = 8'h72;
  localparam logic [7:0] OP_BWR = 8'h57;
  localparam logic [7:0] OP_BRD = 8'h52;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    ADDR,
    DATA,
    STRB,
    ISSUE,
    WAIT
  } state_t;

  function automatic int to_cyc(int us, int mhz);
    return us * mhz;
  endfunction

  function automatic logic is_collect(state_t s);
    return s inside {IDLE, LEN, ADDR, DATA, STRB};
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte gap counter; expire is asserted
// while running and the count sits at TO_CYC-1.
module uart_cmd_timer #(
  parameter int TO_CYC = 5000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] LAST = TW'(TO_CYC - 1);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !run) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign expire = run && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_parser_burst.sv
// Byte-stream single/burst read/write parser
// feeding the register-bus master.
module uart_cmd_parser_burst
  import uart_cmd_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int SW         = DW / 8,
  parameter int CLK_FREQ   = 50,
  parameter int TIMEOUT_US = 100,
  parameter int MAX_BURST  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          apb_en,
  input  logic          strb_en,
  input  logic [7:0]    fifo_data,
  input  logic          fifo_data_valid,
  output logic          fifo_data_req,
  input  logic          uart_rxreq,
  output logic [7:0]    uart_rxdata,
  output logic          uart_rxvld,
  output logic [AW-1:0] cmd_addr,
  output logic [DW-1:0] cmd_wdata,
  output logic [SW-1:0] cmd_strb,
  output logic          cmd_we,
  output logic          cmd_en,
  input  logic          cmd_done,
  output logic          busy,
  output logic          err_timeout
);

  localparam int TO = to_cyc(TIMEOUT_US, CLK_FREQ);
  localparam int AB = AW / 8;
  localparam int DB = DW / 8;
  localparam int NB = (AB > DB) ? AB : DB;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t        state, nxt;
  logic [IW-1:0] idx;
  logic [BW-1:0] beats, beat_cnt;
  logic          is_wr, adv, req_r;
  logic          take, to_hit, last, wr_op;
  logic          expire, t_clr, t_run;
  logic [8:0]    len_p1;

  assign fifo_data_req = apb_en ? req_r : uart_rxreq;
  assign uart_rxdata   = fifo_data & {8{~apb_en}};
  assign uart_rxvld    = fifo_data_valid & ~apb_en;

  always_comb begin
    take   = apb_en & fifo_data_valid & is_collect(state);
    to_hit = apb_en & expire & ~take;
    last   = (beat_cnt == beats - BW'(1));
    wr_op  = (fifo_data == OP_WR) || (fifo_data == OP_BWR);
    len_p1 = {1'b0, fifo_data} + 9'd1;
    nxt    = state;
    if (!apb_en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (take && (fifo_data == OP_WR || fifo_data == OP_RD))
            nxt = ADDR;
          else if (take && (fifo_data == OP_BWR || fifo_data == OP_BRD))
            nxt = LEN;
        end
        LEN: begin
          if (take) nxt = ADDR;
          else if (to_hit) nxt = IDLE;
        end
        ADDR: begin
          if (take && idx == IW'(AB - 1)) nxt = is_wr ? DATA : ISSUE;
          else if (to_hit) nxt = IDLE;
        end
        DATA: begin
          if (take && idx == IW'(DB - 1)) nxt = strb_en ? STRB : ISSUE;
          else if (to_hit) nxt = IDLE;
        end
        STRB: begin
          if (take) nxt = ISSUE;
          else if (to_hit) nxt = IDLE;
        end
        ISSUE: nxt = WAIT;
        WAIT: begin
          if (adv) nxt = is_wr ? DATA : ISSUE;
          else if (cmd_done && last) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  assign t_clr = take || (nxt != state);
  assign t_run = state inside {LEN, ADDR, DATA, STRB};

  uart_cmd_timer #(
    .TO_CYC (TO)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (t_clr),
    .run    (t_run),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      beats       <= '0;
      beat_cnt    <= '0;
      is_wr       <= 1'b0;
      adv         <= 1'b0;
      req_r       <= 1'b0;
      busy        <= 1'b0;
      cmd_en      <= 1'b0;
      cmd_we      <= 1'b0;
      err_timeout <= 1'b0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      cmd_strb    <= '0;
    end else begin
      state       <= nxt;
      busy        <= (nxt != IDLE);
      cmd_en      <= (nxt == ISSUE);
      cmd_we      <= (nxt == ISSUE) && is_wr;
      err_timeout <= to_hit;
      req_r       <= apb_en && is_collect(nxt);
      adv         <= 1'b0;
      if (nxt != state) idx <= '0;
      else if (take) idx <= idx + IW'(1);
      if (take) begin
        case (state)
          IDLE: begin
            is_wr    <= wr_op;
            beats    <= BW'(1);
            beat_cnt <= '0;
          end
          LEN: beats <= (len_p1 > 9'(MAX_BURST)) ?
                        BW'(MAX_BURST) : BW'(len_p1);
          ADDR: cmd_addr[8*int'(idx) +: 8] <= fifo_data;
          DATA: cmd_wdata[8*int'(idx) +: 8] <= fifo_data;
          STRB: cmd_strb <= fifo_data[SW-1:0];
          default: ;
        endcase
      end
      if (nxt == ISSUE && !strb_en) cmd_strb <= '1;
      // address steps on the done edge; ISSUE/DATA follows one cycle later
      if (state == WAIT && apb_en && !adv && cmd_done && !last) begin
        adv      <= 1'b1;
        beat_cnt <= beat_cnt + BW'(1);
        cmd_addr <= cmd_addr + AW'(DB);
      end
    end
  end

endmodule
